mac_array_sched: RTL and testbench

Job sequencer and two-requester arbiter for `mac_array`. It grants one requester at a time round-robin and clears the array accumulators. It then streams that requester's activation/weight beats into the array and tracks outstanding beats until the array's `valid_out` drains. Finally it returns the captured accumulators to the winner over a valid/ready response channel. It replaces hand-driven `start` pulses from `valid_pipeline_ctrl` when more than one producer shares the array.

---
 rtl/mac_sched_pkg.sv | 5 +
 rtl/mac_array_sched_rr_arbiter_2.sv | 22 ++
 rtl/mac_array_sched.sv | 141 ++++++++++++++
 tb/tb_mac_array_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared state encoding and requester count for the mac_array job sequencer
package mac_sched_pkg;
  localparam int NUM_REQ = 2;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, RESP} state_e;
endpackage

// File: rtl/mac_array_sched_rr_arbiter_2.sv
// rr_arbiter_2: two-input round-robin pick with a priority pointer advanced only on response handshake
module rr_arbiter_2
  import mac_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  input  logic               owner,
  output logic               pick
);
  logic prio_q, prio_d;
  // priority holder wins if requesting, otherwise the other requester
  always_comb begin
    prio_d = upd ? ~owner : prio_q;
    pick   = req[prio_q] ? prio_q : ~prio_q;
  end
  // pointer starts at requester 0 and moves past the owner of each completed job
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
endmodule

// File: rtl/mac_array_sched.sv
// mac_array_sched: arbitrates two requesters onto mac_array, streams beats, drains, returns accumulators
// Optional drain watchdog built only when MAC_SCHED_TIMEOUT_EN is defined.
module mac_array_sched
  import mac_sched_pkg::*;
#(
  parameter int W       = 8,
  parameter int ACC_W   = 16,
  parameter int N_MACS  = 4,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*ACC_W-1:0]      req_a,
  input  logic [NUM_REQ*N_MACS*ACC_W-1:0] req_w,
  output logic [N_MACS-1:0]             mac_valid,
  output logic [N_MACS-1:0]             mac_clear,
  output logic [ACC_W-1:0]              mac_a,
  output logic [N_MACS*ACC_W-1:0]       mac_w,
  input  logic [N_MACS*ACC_W-1:0]       mac_acc,
  input  logic [N_MACS-1:0]             mac_valid_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_id,
  output logic [N_MACS*ACC_W-1:0]       rsp_acc,
  output logic                          rsp_err,
  output logic                          busy
);
  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int LW = N_MACS * ACC_W;
  if (W > ACC_W || TIMEOUT < 1) begin : g_cfg_bad
    $error("mac_array_sched: operand width exceeds bus width or TIMEOUT < 1");
  end
  state_e state_q, state_d;
  logic grant_q, grant_d, err_q, err_d, pick, hs, beat, dec, wd_fire;
  logic [CW-1:0] cnt_q, cnt_d, out_q, out_d;
  logic [N_MACS-1:0] mac_valid_q, mac_valid_d;
  logic [ACC_W-1:0] mac_a_q, mac_a_d;
  logic [LW-1:0] mac_w_q, mac_w_d, rsp_acc_q, rsp_acc_d;
  logic [N_MACS-1:0] unused_vo;
  assign unused_vo = mac_valid_out;
  rr_arbiter_2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .upd   (hs),
    .owner (grant_q),
    .pick  (pick)
  );
  assign req_ready = {grant_q, ~grant_q} & {NUM_REQ{state_q == STREAM}};
  assign mac_clear = {N_MACS{state_q == CLEAR}};
  assign mac_valid = mac_valid_q;
  assign mac_a     = mac_a_q;
  assign mac_w     = mac_w_q;
  assign rsp_valid = state_q == RESP;
  assign rsp_id    = grant_q;
  assign rsp_acc   = rsp_acc_q;
  assign rsp_err   = err_q;
  assign busy      = state_q != IDLE;
`ifdef MAC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q, wd_d;
  // count silent drain cycles; any array valid_out restarts the count
  always_comb begin
    wd_d    = (state_q == DRAIN && !mac_valid_out[0]) ? wd_q + 1'b1 : '0;
    wd_fire = state_q == DRAIN && !mac_valid_out[0] && wd_d == TW'(TIMEOUT);
  end
  // watchdog counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
`else
  assign wd_fire = 1'b0;
`endif
  // next-state, beat issue, outstanding tracking and response capture
  always_comb begin
    beat        = state_q == STREAM && req_valid[grant_q];
    dec         = mac_valid_out[0] && out_q != '0;
    hs          = state_q == RESP && rsp_ready;
    state_d     = state_q;
    grant_d     = grant_q;
    err_d       = err_q;
    cnt_d       = beat ? cnt_q + 1'b1 : cnt_q;
    out_d       = out_q + CW'(beat) - CW'(dec);
    mac_valid_d = {N_MACS{beat}};
    mac_a_d     = beat ? (grant_q ? req_a[ACC_W +: ACC_W] : req_a[0 +: ACC_W]) : mac_a_q;
    mac_w_d     = beat ? (grant_q ? req_w[LW +: LW] : req_w[0 +: LW]) : mac_w_q;
    rsp_acc_d   = rsp_acc_q;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d = CLEAR;
        grant_d = pick;
      end
      CLEAR: begin
        state_d = STREAM;
        cnt_d   = '0;
        out_d   = '0;
      end
      STREAM: if (beat && (req_last[grant_q] || cnt_d == CW'(MAX_LEN))) begin
        state_d = DRAIN;
        err_d   = err_q | ~req_last[grant_q];
      end
      DRAIN: if ((out_d == '0 && !mac_valid_q[0]) || wd_fire) begin
        state_d   = RESP;
        rsp_acc_d = mac_acc;
        err_d     = err_q | wd_fire;
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  // sequencer state and registered outputs; reset aborts any job in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      out_q       <= '0;
      mac_valid_q <= '0;
      mac_a_q     <= '0;
      mac_w_q     <= '0;
      rsp_acc_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      mac_valid_q <= mac_valid_d;
      mac_a_q     <= mac_a_d;
      mac_w_q     <= mac_w_d;
      rsp_acc_q   <= rsp_acc_d;
    end
endmodule

// File: tb/tb_mac_array_sched.sv
// tb_mac_array_sched: directed self-checking bench with a behavioural mac_array model
module tb_mac_array_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req_valid = '0, req_ready, req_last = '0;
  logic [31:0] req_a = '0;
  logic [127:0] req_w = '0;
  logic [3:0] mac_valid, mac_clear, mac_valid_out;
  logic [15:0] mac_a;
  logic [63:0] mac_w, mac_acc, rsp_acc;
  logic rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err, busy;
  logic [15:0] acc_m [4] = '{default: '0};
  logic [3:0] vout_m = '0;
  logic suppress = 1'b0;
  int total = 0, bad = 0, w8;

  always #5 clk = ~clk;

  mac_array_sched dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
    .req_a(req_a), .req_w(req_w), .mac_valid(mac_valid), .mac_clear(mac_clear), .mac_a(mac_a),
    .mac_w(mac_w), .mac_acc(mac_acc), .mac_valid_out(mac_valid_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_acc(rsp_acc), .rsp_err(rsp_err), .busy(busy)
  );

  // array model: one-cycle MAC latency, valid_out follows valid_in unless suppressed
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (mac_clear[0]) acc_m[k] <= '0;
      else if (mac_valid[0]) acc_m[k] <= acc_m[k] + 16'(mac_a * mac_w[k*16 +: 16]);
    vout_m <= suppress ? 4'h0 : mac_valid;
  end
  assign mac_acc = {acc_m[3], acc_m[2], acc_m[1], acc_m[0]};
  assign mac_valid_out = vout_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input int id, input logic [15:0] a, input logic [15:0] w0, input logic last);
    req_valid[id] = 1'b1;
    req_last[id] = last;
    req_a[id*16 +: 16] = a;
    for (int k = 0; k < 4; k++) req_w[(id*4+k)*16 +: 16] = 16'(w0 + 16'(k));
  endtask

  task automatic send(input int id, input logic [15:0] a, input logic [15:0] w0, input logic last,
                      output int waited);
    setup(id, a, w0, last);
    waited = 0;
    while (!req_ready[id] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("beat_ready", 64'(req_ready[id]), 64'd1);
    @(negedge clk);
    check("beat_mac_valid", 64'(mac_valid), 64'hf);
    check("beat_mac_a", 64'(mac_a), 64'(a));
    req_valid[id] = 1'b0;
    req_last[id] = 1'b0;
  endtask

  task automatic take(input string tag, input logic [1:0] exp);
    int n = 0;
    while (req_ready == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(req_ready), 64'(exp));
    @(negedge clk);
    req_valid = req_valid & ~exp;
  endtask

  task automatic wait_rsp(input string tag, input logic id, input logic [15:0] l0, input logic err);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check({tag, "_id"}, 64'(rsp_id), 64'(id));
    check({tag, "_lane0"}, 64'(rsp_acc[15:0]), 64'(l0));
    check({tag, "_err"}, 64'(rsp_err), 64'(err));
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_outs", {rsp_valid, rsp_id, rsp_err, req_ready, mac_valid, mac_clear}, 64'd0);
    check("rst_data", {mac_a, rsp_acc[15:0], mac_w[31:0]}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    // single beat, requester 0, with latency checks
    setup(0, 16'd10, 16'd2, 1'b1);
    @(negedge clk);
    check("t1_clear", 64'(mac_clear), 64'hf);
    check("t1_ready_early", 64'(req_ready), 64'd0);
    @(negedge clk);
    check("t1_clear_once", 64'(mac_clear), 64'd0);
    check("t1_ready", 64'(req_ready), 64'b01);
    @(negedge clk);
    check("t1_mac_valid", 64'(mac_valid), 64'hf);
    check("t1_mac_a", 64'(mac_a), 64'd10);
    req_valid = '0;
    req_last = '0;
    wait_rsp("t1", 1'b0, 16'd20, 1'b0);
    check("t1_lane1", 64'(rsp_acc[31:16]), 64'd30);
    check("t1_idle", 64'(busy), 64'd0);
    // back-to-back jobs prove the accumulators are cleared between them
    send(0, 16'd10, 16'd2, 1'b1, w8);
    wait_rsp("t2a", 1'b0, 16'd20, 1'b0);
    send(0, 16'd5, 16'd2, 1'b1, w8);
    wait_rsp("t2b", 1'b0, 16'd10, 1'b0);
    // three-beat dot product from requester 1, issued on consecutive cycles
    send(1, 16'd1, 16'd2, 1'b0, w8);
    send(1, 16'd2, 16'd3, 1'b0, w8);
    check("t3_b2b_2", 64'(w8), 64'd0);
    send(1, 16'd3, 16'd4, 1'b1, w8);
    check("t3_b2b_3", 64'(w8), 64'd0);
    wait_rsp("t3", 1'b1, 16'd20, 1'b0);
    check("t3_lane3", 64'(rsp_acc[63:48]), 64'd38);
    // both valid at reset exit: 0 then 1, then 0 again
    rst_n = 1'b0;
    setup(0, 16'd3, 16'd2, 1'b1);
    setup(1, 16'd4, 16'd5, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    take("t4_first", 2'b01);
    wait_rsp("t4a", 1'b0, 16'd6, 1'b0);
    take("t4_second", 2'b10);
    wait_rsp("t4b", 1'b1, 16'd20, 1'b0);
    setup(0, 16'd1, 16'd1, 1'b1);
    setup(1, 16'd2, 16'd1, 1'b1);
    take("t4_third", 2'b01);
    wait_rsp("t4c", 1'b0, 16'd1, 1'b0);
    take("t4_fourth", 2'b10);
    wait_rsp("t4d", 1'b1, 16'd2, 1'b0);
    // MAX_LEN truncation: 16 beats accepted, 17th refused
    setup(0, 16'd1, 16'd1, 1'b0);
    begin
      int n = 0;
      while (!req_ready[0] && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("t5_ready", 64'(req_ready), 64'b01);
    repeat (16) @(negedge clk);
    check("t5_beat17", 64'(req_ready), 64'd0);
    req_valid = '0;
    wait_rsp("t5", 1'b0, 16'd16, 1'b1);
    check("t5_lane1", 64'(rsp_acc[31:16]), 64'd32);
    // drain with the array's valid_out suppressed
    suppress = 1'b1;
    send(0, 16'd7, 16'd3, 1'b1, w8);
    begin
      int n = 0;
      while (!rsp_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
`ifdef MAC_SCHED_TIMEOUT_EN
      check("t6_wd_cycles", 64'(n), 64'd64);
      check("t6_err", 64'(rsp_err), 64'd1);
      check("t6_lane0", 64'(rsp_acc[15:0]), 64'd21);
      @(negedge clk);
`else
      check("t6_hang_busy", 64'(busy), 64'd1);
      check("t6_no_rsp", 64'(rsp_valid), 64'd0);
`endif
    end
    suppress = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // reset asserted mid-stream aborts at once
    setup(1, 16'd9, 16'd9, 1'b0);
    begin
      int n = 0;
      while (!req_ready[1] && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    check("t7_streaming", {req_ready, mac_valid}, {2'b10, 4'hf});
    #2 rst_n = 1'b0;
    #1;
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_outs", {rsp_valid, rsp_err, req_ready, mac_valid, mac_clear}, 64'd0);
    check("t7_data", {mac_a, mac_w[47:0]}, 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t7_after", {busy, rsp_valid, mac_clear}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
